// File: rtl/ir_nec_tx_if.sv
// Request-side bundle of the NEC IR transmitter: frame payload, valid/ready
// handshake, repeat-hold request and busy status.
interface ir_nec_tx_if;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       valid;
  logic       ready;
  logic       hold;
  logic       busy;

  modport master (output addr, cmd, valid, hold, input ready, busy);
  modport slave  (input addr, cmd, valid, hold, output ready, busy);
endinterface

// File: rtl/ir_nec_tx.sv
// NEC IR transmitter: serialises addr/cmd into a carrier-modulated frame on
// the LED pin and emits repeat codes while hold stays high.
module ir_nec_tx #(
  parameter int T_UNIT       = 56000,
  parameter int CARR_HALF    = 1316,
  parameter int FRAME_PERIOD = 10800000
) (
  input  logic        clk,
  input  logic        rst,
  ir_nec_tx_if.slave  bus,
  output logic        ir_env,
  output logic        ir_led
);

  localparam int UW = $clog2(16 * T_UNIT);
  localparam int PW = $clog2(FRAME_PERIOD + 1);
  localparam int CW = (CARR_HALF > 1) ? $clog2(CARR_HALF) : 1;

  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP,
    RPT_MARK, RPT_SPACE, RPT_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [PW-1:0] per_q, per_d;
  logic [31:0]   shift_q, shift_d;
  logic [5:0]    bit_q, bit_d;
  logic [CW-1:0] carr_cnt_q, carr_cnt_d;
  logic          carr_hi_q, carr_hi_d;
  logic [UW-1:0] seg_last;
  logic          seg_end;
  logic          per_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      unit_q     <= '0;
      per_q      <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      carr_cnt_q <= '0;
      carr_hi_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_q     <= unit_d;
      per_q      <= per_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      carr_cnt_q <= carr_cnt_d;
      carr_hi_q  <= carr_hi_d;
    end
  end

  always_comb begin
    seg_last = '0;
    case (state_q)
      LEAD_MARK, RPT_MARK:           seg_last = UW'(16 * T_UNIT - 1);
      LEAD_SPACE:                    seg_last = UW'(8 * T_UNIT - 1);
      RPT_SPACE:                     seg_last = UW'(4 * T_UNIT - 1);
      BIT_SPACE:                     seg_last = shift_q[0] ? UW'(3 * T_UNIT - 1) : UW'(T_UNIT - 1);
      BIT_MARK, STOP_MARK, RPT_STOP: seg_last = UW'(T_UNIT - 1);
      default:                       seg_last = '0;
    endcase
  end

  assign seg_end  = (unit_q == seg_last);
  assign per_done = (per_q == PW'(FRAME_PERIOD));

  // The period counter reads 1 on the first mark cycle and saturates, so GAP
  // ends on the last cycle before the next frame slot (or at once if overrun).
  always_comb begin
    state_d = state_q;
    unit_d  = unit_q + 1'b1;
    per_d   = per_done ? per_q : per_q + 1'b1;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        unit_d = '0;
        per_d  = '0;
        if (bus.valid) begin
          state_d = LEAD_MARK;
          shift_d = {~bus.cmd, bus.cmd, ~bus.addr, bus.addr};
          bit_d   = '0;
          per_d   = PW'(1);
        end
      end
      LEAD_MARK:  if (seg_end) state_d = LEAD_SPACE;
      LEAD_SPACE: if (seg_end) state_d = BIT_MARK;
      BIT_MARK:   if (seg_end) state_d = BIT_SPACE;
      BIT_SPACE: begin
        if (seg_end) begin
          state_d = (bit_q == 6'd31) ? STOP_MARK : BIT_MARK;
          bit_d   = bit_q + 6'd1;
          shift_d = {1'b0, shift_q[31:1]};
        end
      end
      STOP_MARK:  if (seg_end) state_d = GAP;
      GAP: begin
        unit_d = '0;
        if (per_done) begin
          if (bus.hold) begin
            state_d = RPT_MARK;
            per_d   = PW'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      RPT_MARK:   if (seg_end) state_d = RPT_SPACE;
      RPT_SPACE:  if (seg_end) state_d = RPT_STOP;
      RPT_STOP:   if (seg_end) state_d = GAP;
      default:    state_d = IDLE;
    endcase
    if (state_d != state_q) unit_d = '0;
  end

  // Carrier phase restarts high on every segment boundary so marks begin lit.
  always_comb begin
    carr_cnt_d = carr_cnt_q + 1'b1;
    carr_hi_d  = carr_hi_q;
    if (state_d != state_q) begin
      carr_cnt_d = '0;
      carr_hi_d  = 1'b1;
    end else if (carr_cnt_q == CW'(CARR_HALF - 1)) begin
      carr_cnt_d = '0;
      carr_hi_d  = ~carr_hi_q;
    end
  end

  always_comb begin
    ir_env = (state_q == LEAD_MARK) || (state_q == BIT_MARK) || (state_q == STOP_MARK) ||
             (state_q == RPT_MARK) || (state_q == RPT_STOP);
    ir_led = ir_env && carr_hi_q;
    bus.ready = (state_q == IDLE);
    bus.busy  = (state_q != IDLE);
  end

endmodule
